// File: rtl/bus_pkg.sv
// bus_pkg: shared types and constants for the serial system bus arbiter
package bus_pkg;
    localparam int SEL_BITS = 2;
    localparam int NUM_SLAVES = 3;
    localparam int TIMEOUT_DEFAULT = 64;
    typedef enum logic [1:0] {IDLE, SELECT, CONNECT, RELEASE} state_t;
    typedef enum logic {M1 = 1'b0, M2 = 1'b1} owner_t;
endpackage

// File: rtl/bus_arbiter_rr_grant.sv
// rr_grant: two-requester round-robin pick favouring the master that did not own the bus last
module rr_grant import bus_pkg::*; (
    input  logic   req1,
    input  logic   req2,
    input  owner_t last_owner,
    output logic   req_any,
    output owner_t pick
);
    assign req_any = req1 | req2;
    assign pick = (req1 && req2) ? (last_owner == M1 ? M2 : M1) : (req1 ? M1 : M2);
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: grants the bus to one of two masters, decodes a serial slave prefix and routes to one of three slaves
module bus_arbiter import bus_pkg::*; #(
    parameter int SEL_BITS = bus_pkg::SEL_BITS,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m1_request,
    input  logic                  m2_request,
    input  logic                  m1_valid,
    input  logic                  m2_valid,
    input  logic                  m1_tx_address,
    input  logic                  m2_tx_address,
    input  logic                  m1_tx_data,
    input  logic                  m2_tx_data,
    input  logic [NUM_SLAVES-1:0] s_ready,
    input  logic [NUM_SLAVES-1:0] s_done,
    output logic                  m1_grant,
    output logic                  m2_grant,
    output logic [NUM_SLAVES-1:0] s_valid,
    output logic                  bus_address,
    output logic                  bus_data,
    output logic                  m1_slave_ready,
    output logic                  m2_slave_ready,
    output logic                  timeout,
    output logic                  decode_error
);
    localparam int NS = 2 ** SEL_BITS;
    localparam int CW = $clog2(SEL_BITS + 1);
    state_t state, state_n;
    owner_t last_owner, owner_n, pick;
    logic [SEL_BITS-1:0] sel, sel_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [6:0] tcnt, tcnt_n;
    logic to_n, de_n, req_any, o_req, o_valid, o_addr, o_data, con;
    logic [NS-1:0] rdy_ext, done_ext;
    rr_grant u_rr (
        .req1(m1_request),
        .req2(m2_request),
        .last_owner(last_owner),
        .req_any(req_any),
        .pick(pick)
    );
    assign o_req = last_owner == M1 ? m1_request : m2_request;
    assign o_valid = last_owner == M1 ? m1_valid : m2_valid;
    assign o_addr = last_owner == M1 ? m1_tx_address : m2_tx_address;
    assign o_data = last_owner == M1 ? m1_tx_data : m2_tx_data;
    // widened so a not-yet-decoded sel of 3 indexes a harmless zero
    assign rdy_ext = NS'(s_ready);
    assign done_ext = NS'(s_done);
    assign con = state == CONNECT;
    assign s_valid = (con && o_valid) ? NUM_SLAVES'(1) << sel : '0;
    assign bus_address = con & o_addr;
    assign bus_data = con & o_data;
    assign m1_slave_ready = con && last_owner == M1 && rdy_ext[sel];
    assign m2_slave_ready = con && last_owner == M2 && rdy_ext[sel];
    always_comb begin
        state_n = state;
        owner_n = last_owner;
        sel_n = sel;
        cnt_n = cnt;
        tcnt_n = tcnt;
        to_n = 1'b0;
        de_n = 1'b0;
        case (state)
            IDLE: if (req_any) begin
                state_n = SELECT;
                owner_n = pick;
                sel_n = '0;
                cnt_n = '0;
            end
            SELECT: if (!o_req) begin
                state_n = RELEASE;
            end else if (o_valid) begin
                sel_n = (sel << 1) | SEL_BITS'(o_addr);
                cnt_n = cnt + 1'b1;
                if (cnt_n == CW'(SEL_BITS)) begin
                    state_n = int'(sel_n) < NUM_SLAVES ? CONNECT : RELEASE;
                    de_n = int'(sel_n) >= NUM_SLAVES;
                    tcnt_n = '0;
                end
            end
            CONNECT: if (!o_req) begin
                state_n = RELEASE;
            end else if (rdy_ext[sel] || done_ext[sel]) begin
                tcnt_n = '0;
            end else begin
                tcnt_n = tcnt + 1'b1;
                to_n = tcnt_n == 7'(TIMEOUT);
                state_n = to_n ? RELEASE : CONNECT;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            last_owner <= M2;
            sel <= '0;
            cnt <= '0;
            tcnt <= '0;
            m1_grant <= 1'b0;
            m2_grant <= 1'b0;
            timeout <= 1'b0;
            decode_error <= 1'b0;
        end else begin
            state <= state_n;
            last_owner <= owner_n;
            sel <= sel_n;
            cnt <= cnt_n;
            tcnt <= tcnt_n;
            m1_grant <= (state_n == SELECT || state_n == CONNECT) && owner_n == M1;
            m2_grant <= (state_n == SELECT || state_n == CONNECT) && owner_n == M2;
            timeout <= to_n;
            decode_error <= de_n;
        end
    end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, three-slave arbiter and router for the serial system bus. Grants the bus to one master at a time with round-robin fairness. Decodes a 2-bit serial slave-select prefix sent by the granted master, then connects that master's serial lines and handshakes to the chosen `slave_in_port`. Sits between the master ports and the slave ports, and owns the bus from grant to release.

## Interface
Parameters:
- `SEL_BITS`, 2: width of the serial slave-select prefix; values 0..2 are valid, 3 is a decode error.
- `TIMEOUT`, 64: CONNECT cycles allowed without slave activity before forced release; counter is 7 bits.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `m1_request`, `m2_request`  in  1  bus request, held high for the whole transaction.
- `m1_valid`, `m2_valid`  in  1  master_valid from each master.
- `m1_tx_address`, `m2_tx_address`  in  1  serial address line of each master; carries select prefix then address.
- `m1_tx_data`, `m2_tx_data`  in  1  serial write-data line of each master.
- `s_ready`  in  3  slave_ready from slaves 0..2.
- `s_done`  in  3  rx_done from slaves 0..2.
- `m1_grant`, `m2_grant`  out  1  registered grant.
- `s_valid`  out  3  one-hot master_valid to the selected slave.
- `bus_address`, `bus_data`  out  1  granted master's serial lines; forwarded only in CONNECT, 0 otherwise.
- `m1_slave_ready`, `m2_slave_ready`  out  1  selected slave's ready, returned to the owner only.
- `timeout`, `decode_error`  out  1  one-cycle pulses.

## Operation
States:
- **IDLE**
  - No request: stay.
  - One requester: grant it.
  - Both requesting: grant the master that is not `last_owner`.
  - On a grant, `last_owner` updates and the FSM goes to SELECT.
- **SELECT**
  - Each cycle with owner valid=1, shift owner tx_address into `sel`, MSB first, and increment the bit count.
  - When SEL_BITS bits are captured: `sel`<3 goes to CONNECT; `sel`=3 pulses `decode_error` and goes to RELEASE.
  - Cycles with valid=0 do not shift.
  - Owner request low goes to RELEASE.
  - Prefix bits are never forwarded to any slave.
- **CONNECT**
  - `s_valid[sel]` = owner valid; `bus_address`/`bus_data` = owner lines; owner slave_ready = `s_ready[sel]`.
  - Timeout counter clears on entry and whenever `s_ready[sel]` or `s_done[sel]` is high; otherwise it increments.
  - Counter reaching TIMEOUT pulses `timeout` and goes to RELEASE.
  - Owner request low goes to RELEASE; request low wins if it coincides with timeout (no pulse).
- **RELEASE**
  - One dead cycle: grants low, all routing outputs 0.
  - Then IDLE unconditionally.

Rules:
- The non-owner's request, valid and lines are ignored in every state except IDLE.
- Reset (`reset`=0 at an edge), from any state:
  - state IDLE, `last_owner`=M2 (so M1 wins the first tie), `sel`, bit count and timeout counter 0.
  - All outputs 0: grants, `s_valid`, bus lines, slave_ready returns, `timeout`, `decode_error`.
  - A transaction cut by reset is abandoned; no pulse.

## Timing
- Grants are registered. Request high at edge k in IDLE gives grant high after edge k.
- The first prefix bit is sampled at the first edge where state=SELECT and valid=1.
- With valid held high, CONNECT starts SEL_BITS edges after grant.
- CONNECT routing is combinational from state/`sel`: owner valid and lines reach the slave in the same cycle.
- `timeout`/`decode_error` are registered, high for exactly the cycle after the detecting edge.
- Request drop at edge n: RELEASE after n, IDLE after n+1. Earliest re-grant is visible after edge n+2.
- Back-to-back both-requesting transactions alternate M1, M2, M1, ...

## Structure
- Shared package `bus_pkg`:
  - state enum (IDLE, SELECT, CONNECT, RELEASE).
  - `SEL_BITS`.
  - slave count 3.
  - `TIMEOUT` default.
  - owner encoding (M1=0, M2=1).
- One sub-module: `rr_grant`, a 2-requester round-robin pick from requests and `last_owner`.
- FSM, shifter, counter and muxes stay in `bus_arbiter`.

## Test plan
- Reset mid-CONNECT: `reset`=0 for one edge leaves all outputs 0 and state IDLE; a following M1 request is granted one cycle later.
- M1 alone, prefix 1,0 (sel=2), then 12 address bits 1011 1101 0011:
  - `s_valid`=3'b100 exactly for the address cycles.
  - `bus_address` replays the 12 bits.
  - `m1_slave_ready` follows `s_ready[2]`.
  - Request drop gives one RELEASE cycle.
- Both request in the same cycle after reset: M1 granted. On M1 release with M2 still high, M2 is granted 2 cycles later. A third simultaneous round goes to M1.
- Prefix 1,1: `decode_error` pulses once, `s_valid` never leaves 0, grant drops after RELEASE.
- Selected slave silent in CONNECT with TIMEOUT=64: `timeout` pulses on the 64th idle cycle, then RELEASE. A repeat with `s_ready` asserted every 50 cycles never times out.
- M2 toggles valid/lines while M1 is owner: no effect on `s_valid`, bus lines or `m2_slave_ready` (stays 0).
